// File: rtl/comm_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comm_pkg
// Brief    : Shared types and constants for the UART command arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package comm_pkg;

    localparam int CMD_W = 16;
    localparam int RSP_W = 8;
    localparam logic [RSP_W-1:0] TMO_RESP = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_TX  = 2'd2,
        WAIT_RSP = 2'd3
    } comm_state_t;

endpackage
`default_nettype wire

// File: rtl/comm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : comm_arbiter_if
// Brief    : Requester-side and comm-master-side signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface comm_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import comm_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic [RSP_W-1:0]         resp;
    logic                     tmo;

    logic                     snd_cmd;
    logic [CMD_W-1:0]         cmd;
    logic                     cmd_cmplt;
    logic                     rdy;
    logic [RSP_W-1:0]         rx_data;
    logic                     clr_rdy;

    // master: the arbiter itself; slave: requesters plus the comm master
    modport master (
        input  req, req_cmd, cmd_cmplt, rdy, rx_data,
        output gnt, done, resp, tmo, snd_cmd, cmd, clr_rdy
    );

    modport slave (
        output req, req_cmd, cmd_cmplt, rdy, rx_data,
        input  gnt, done, resp, tmo, snd_cmd, cmd, clr_rdy
    );

endinterface
`default_nettype wire

// File: rtl/comm_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : comm_rr_pick
// Brief    : Combinational round-robin selector, searching upward from ptr+1.
// Revision : 1.0 - initial release
// ============================================================================
module comm_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   win_idx
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        any     = |req;
        win_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                win_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/comm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : comm_arbiter
// Brief    : Round-robin sharing of one UART command master among requesters.
//            Define COMM_TMO_EN to enable the response timeout path.
// Revision : 1.0 - initial release
// ============================================================================
module comm_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TMO_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst,
    comm_arbiter_if.master bus
);
    import comm_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    comm_state_t         r_state;
    comm_state_t         w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_any;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [CMD_W-1:0]    r_cmd;
    logic [RSP_W-1:0]    r_resp;
    logic                w_snd_cmd;
    logic                w_clr_rdy;
    logic                w_rsp_ok;
    logic                w_tmo_hit;
    logic                w_finish;

    comm_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (bus.req),
        .ptr     (r_ptr),
        .any     (w_any),
        .win_idx (w_win_idx)
    );

    assign w_rsp_ok = (r_state == WAIT_RSP) && bus.rdy;
    assign w_finish = w_rsp_ok || w_tmo_hit;

`ifdef COMM_TMO_EN
    localparam int              CNT_W    = $clog2(TMO_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tmo;

    // rdy in the same cycle as the last count takes priority over timeout
    assign w_tmo_hit = (r_state == WAIT_RSP) && !bus.rdy && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == WAIT_TX) && bus.cmd_cmplt) begin
            r_cnt <= '0;
        end else if ((r_state == WAIT_RSP) && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= 1'b0;
        end else if (w_finish) begin
            r_tmo <= !w_rsp_ok;
        end
    end

    assign bus.tmo = r_tmo;
`else
    assign w_tmo_hit = 1'b0;
    assign bus.tmo   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snd_cmd   = 1'b0;
        w_clr_rdy   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                // clr_rdy here discards any byte left over from earlier traffic
                w_snd_cmd   = 1'b1;
                w_clr_rdy   = 1'b1;
                w_state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.cmd_cmplt) begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                w_clr_rdy = bus.rdy;
                if (w_finish) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_ptr  <= IDX_W'(NUM_REQ - 1);
            r_gnt  <= '0;
            r_done <= '0;
            r_cmd  <= '0;
            r_resp <= '0;
        end else begin
            r_done <= '0;
            if ((r_state == IDLE) && w_any) begin
                r_idx <= w_win_idx;
                r_cmd <= bus.req_cmd[w_win_idx*CMD_W +: CMD_W];
                r_gnt <= NUM_REQ'(1) << w_win_idx;
            end
            if (w_finish) begin
                r_resp <= w_rsp_ok ? bus.rx_data : TMO_RESP;
                r_done <= r_gnt;
                r_gnt  <= '0;
                r_ptr  <= r_idx;
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.resp    = r_resp;
    assign bus.snd_cmd = w_snd_cmd;
    assign bus.cmd     = r_cmd;
    assign bus.clr_rdy = w_clr_rdy;

endmodule
`default_nettype wire

// File: doc/comm_arbiter.md
# comm_arbiter

Shares the single UART command master between up to `NUM_REQ` requesters. Each transaction sends one 16-bit command and collects the 8-bit response byte. Requesters are granted round-robin. The block drives the master's `snd_cmd`/`cmd`, waits for `cmd_cmplt` and then `rdy`, consumes the byte with `clr_rdy`, and returns it to the granted requester. It sits between the command-producing logic and the comm master.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `TMO_CYCLES`, 50000: response timeout in clk cycles, ≥2 (used only with `COMM_TMO_EN`)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NUM_REQ  requester i holds high while `req_cmd[i]` is valid
- `req_cmd`  in  NUM_REQ*16  packed commands; slice i = bits [16i+15:16i]
- `gnt`  out  NUM_REQ  one-hot, registered; high for the granted requester from SEND through WAIT_RSP
- `done`  out  NUM_REQ  one-hot, one-cycle pulse; `resp` and `tmo` valid with it
- `resp`  out  8  response byte (8'hFF on timeout)
- `tmo`  out  1  qualifies `done`: the transaction timed out
- `snd_cmd`  out  1  one-cycle send strobe to the master
- `cmd`  out  16  latched command to the master
- `cmd_cmplt`  in  1  master finished transmitting both bytes
- `rdy`  in  1  master holds a received byte
- `rx_data`  in  8  received byte
- `clr_rdy`  out  1  consume the received byte

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_RSP.
- **IDLE:** if any `req` bit is set:
  - pick the winner by round-robin, searching from `ptr+1` upward mod `NUM_REQ`; `ptr` is the last-granted index;
  - latch the winner's index into `idx` and its `req_cmd` slice into `cmd`;
  - set `gnt[idx]`; go to SEND.
- **SEND:** `snd_cmd`=1 and `clr_rdy`=1, which flushes any stale byte. Go to WAIT_TX.
- **WAIT_TX:**
  - ignore `rdy`;
  - on `cmd_cmplt`, clear the timeout counter and go to WAIT_RSP.
- **WAIT_RSP:** on `rdy`:
  - `clr_rdy`=1 that cycle; `resp`←`rx_data`; `tmo`←0;
  - next cycle: `done[idx]` pulses, `gnt` clears, `ptr`←`idx`, state is IDLE.
- **Timeout** (`COMM_TMO_EN` only): if the counter reaches `TMO_CYCLES-1` with `rdy` low:
  - `resp`←8'hFF, `tmo`←1;
  - `done`/`gnt`/`ptr` update exactly as for a normal response.
- `rdy` and timeout in the same cycle: `rdy` wins (normal response).
- Requester drops `req` after grant: the transaction still completes and `done` still pulses to it.
- Requester must hold `req` low in its `done` cycle to avoid re-request. A request still high in that cycle is eligible in the same IDLE cycle, at lowest priority.
- Reset, including mid-transaction:
  - state←IDLE; `gnt`, `done`, `tmo`, `snd_cmd`, `clr_rdy`←0;
  - `resp`←0, `cmd`←0;
  - `ptr`←`NUM_REQ-1`, so requester 0 has first priority;
  - timeout counter←0.

## Timing
- Request seen in IDLE at cycle 0 → `gnt`, `cmd` valid and `snd_cmd` in cycle 1 (SEND) → WAIT_TX from cycle 2.
- `cmd` is stable from SEND until the next grant.
- `cmd_cmplt` in cycle t → WAIT_RSP in t+1.
- `rdy` observed in cycle r → `clr_rdy` in r, `done`/`resp` in r+1.
- A new grant can occur in r+1, so back-to-back transactions take one idle cycle.
- Timeout: `done` follows exactly `TMO_CYCLES` WAIT_RSP cycles without `rdy`.
- Counter width: `$clog2(TMO_CYCLES)`; it saturates and never wraps.

## Configuration
- `COMM_TMO_EN` defined: the timeout counter and timeout path are present.
- `COMM_TMO_EN` undefined:
  - WAIT_RSP waits for `rdy` indefinitely;
  - `tmo` is tied 0;
  - no counter is synthesized.

## Structure
- Package `comm_pkg` holds:
  - the `comm_state_t` enum (IDLE, SEND, WAIT_TX, WAIT_RSP);
  - `CMD_W`=16, `RSP_W`=8;
  - `TMO_RESP`=8'hFF.
- Sub-module `comm_rr_pick`: combinational round-robin selector. Inputs `req`, `ptr`; outputs `any`, `win_idx`. Parameterized by `NUM_REQ`.

## Test plan
- Single request: `req`=4'b0001, cmd 16'hA5C3; `cmd_cmplt` after 20 cycles, `rdy` with 8'h3C 5 cycles later → one `snd_cmd` with `cmd`=16'hA5C3, `clr_rdy` in SEND and in the `rdy` cycle, `done`=4'b0001, `resp`=8'h3C, `tmo`=0.
- Contention: `req`=4'b1111 held continuously → grant order 0,1,2,3,0; each `done` is one-hot and matches the preceding `gnt`.
- Stale byte: `rdy` held high when entering SEND → flushed by `clr_rdy` in SEND; no `done` until a fresh `rdy` arrives after `cmd_cmplt`.
- Timeout (`COMM_TMO_EN`, `TMO_CYCLES`=8): no `rdy` after `cmd_cmplt` → `done` exactly 8 cycles into WAIT_RSP with `resp`=8'hFF, `tmo`=1. With `rdy` arriving in the 8th cycle → normal response, `tmo`=0.
- Reset mid-transaction: `rst`=1 in WAIT_RSP → next cycle all outputs 0, state IDLE. With `req`=4'b1010 afterwards → requester 1 is granted first.
